// File: rtl/ram_be_arbiter_pkg.sv
// Shared definitions for the two-requester byte-enable RAM arbiter.
package ram_be_arbiter_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned MAX_LOCK_DEF   = 4;

    // Lock FSM encodings
    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    // Tag travelling with an accepted read until its data returns
    typedef struct packed {
        logic vld;
        logic who;
    } rd_tag_t;

endpackage

// File: rtl/ram_be_arbiter_if.sv
// Requester-side bus of the arbiter: two request/grant ports plus shared read data.
interface ram_be_arbiter_if
    import ram_be_arbiter_pkg::*;
#(
    parameter int unsigned Word_Width = WORD_WIDTH_DEF,
    parameter int unsigned Addr_Width = ADDR_WIDTH_DEF
);
    localparam int unsigned Byte_Width = Word_Width / 8;

    logic                  req0_i;
    logic                  req1_i;
    logic [Byte_Width-1:0] be0_i;
    logic [Byte_Width-1:0] be1_i;
    logic [Addr_Width-1:0] addr0_i;
    logic [Addr_Width-1:0] addr1_i;
    logic [Word_Width-1:0] data0_i;
    logic [Word_Width-1:0] data1_i;
    logic                  lock0_i;
    logic                  lock1_i;
    logic                  gnt0_o;
    logic                  gnt1_o;
    logic                  rvalid0_o;
    logic                  rvalid1_o;
    logic [Word_Width-1:0] rdata_o;

    modport master (
        output req0_i, req1_i, be0_i, be1_i, addr0_i, addr1_i,
               data0_i, data1_i, lock0_i, lock1_i,
        input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o
    );

    modport slave (
        input  req0_i, req1_i, be0_i, be1_i, addr0_i, addr1_i,
               data0_i, data1_i, lock0_i, lock1_i,
        output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o
    );

endinterface

// File: rtl/ram_be_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer; allow masks come from the lock FSM.
module ram_be_arbiter_rr_arb2 (
    input  logic clk,
    input  logic rstn,
    input  logic req0,
    input  logic req1,
    input  logic allow0,
    input  logic allow1,
    output logic gnt0_c,
    output logic gnt1_c
);
    logic ptr;
    logic r0;
    logic r1;

    // Masked requests; ptr=0 favours requester 0
    always_comb begin
        r0     = req0 & allow0;
        r1     = req1 & allow1;
        gnt0_c = r0 & (~r1 | ~ptr);
        gnt1_c = r1 & (~r0 | ptr);
    end

    // The requester granted last drops to lower priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (gnt0_c) begin
            ptr <= 1'b1;
        end else if (gnt1_c) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_be_arbiter.sv
// Shares one byte-enable RAM port between two requesters with round-robin and bounded lock.
module ram_be_arbiter
    import ram_be_arbiter_pkg::*;
#(
    parameter int unsigned Word_Width = WORD_WIDTH_DEF,
    parameter int unsigned Addr_Width = ADDR_WIDTH_DEF,
    parameter int unsigned Max_Lock   = MAX_LOCK_DEF
) (
    input  logic                            clk,
    input  logic                            rstn,
    ram_be_arbiter_if.slave                 bus,
    output logic                            ram_cen_o,
    output logic                            ram_oen_o,
    output logic [Word_Width/8-1:0]         ram_wen_o,
    output logic [Addr_Width-1:0]           ram_addr_o,
    output logic [Word_Width-1:0]           ram_data_o,
    input  logic [Word_Width-1:0]           ram_data_i
);
    localparam int unsigned Byte_Width = Word_Width / 8;
    localparam int unsigned Cnt_Width  = $clog2(Max_Lock + 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [Cnt_Width-1:0]  cnt;
    logic [Cnt_Width-1:0]  cnt_nxt;
    logic [Cnt_Width-1:0]  cnt_inc;
    logic                  allow0;
    logic                  allow1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  accept;
    logic                  sel1;
    logic                  own_gnt;
    logic                  own_lock;
    logic                  oth_req;
    logic                  at_max;
    logic [Byte_Width-1:0] acc_be;
    logic [Addr_Width-1:0] acc_addr;
    logic [Word_Width-1:0] acc_data;
    rd_tag_t               tag_q;
    logic                  rvalid0;
    logic                  rvalid1;

    // A locked owner excludes the other requester
    assign allow0 = (state != ST_LOCK1);
    assign allow1 = (state != ST_LOCK0);

    ram_be_arbiter_rr_arb2 u_rr (
        .clk    (clk),
        .rstn   (rstn),
        .req0   (bus.req0_i),
        .req1   (bus.req1_i),
        .allow0 (allow0),
        .allow1 (allow1),
        .gnt0_c (gnt0),
        .gnt1_c (gnt1)
    );

    assign accept        = gnt0 | gnt1;
    assign acc_be        = gnt1 ? bus.be1_i   : bus.be0_i;
    assign acc_addr      = gnt1 ? bus.addr1_i : bus.addr0_i;
    assign acc_data      = gnt1 ? bus.data1_i : bus.data0_i;
    assign bus.gnt0_o    = gnt0;
    assign bus.gnt1_o    = gnt1;
    assign bus.rvalid0_o = rvalid0;
    assign bus.rvalid1_o = rvalid1;
    assign bus.rdata_o   = ram_data_i;

    // View of the current or prospective lock owner versus the other requester
    always_comb begin
        sel1     = (state == ST_LOCK1) | ((state == ST_ARB) & gnt1);
        own_gnt  = sel1 ? gnt1        : gnt0;
        own_lock = sel1 ? bus.lock1_i : bus.lock0_i;
        oth_req  = sel1 ? bus.req0_i  : bus.req1_i;
        cnt_inc  = oth_req ? (cnt + Cnt_Width'(1)) : '0;
        at_max   = (cnt_inc == Cnt_Width'(Max_Lock));
    end

    // Lock FSM next state and hold counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_ARB: begin
                if (own_gnt && own_lock && !at_max) begin
                    state_nxt = sel1 ? ST_LOCK1 : ST_LOCK0;
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (own_gnt) begin
                    if (!own_lock || at_max) begin
                        state_nxt = ST_ARB;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else if (oth_req) begin
                    state_nxt = ST_ARB;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_ARB;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_ARB;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RAM command register: one beat per accepted request, idle otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_cen_o  <= 1'b1;
            ram_oen_o  <= 1'b1;
            ram_wen_o  <= '1;
            ram_addr_o <= '0;
            ram_data_o <= '0;
        end else begin
            ram_oen_o <= 1'b0;
            ram_cen_o <= ~accept;
            if (accept) begin
                ram_wen_o  <= ~acc_be;
                ram_addr_o <= acc_addr;
                ram_data_o <= acc_data;
            end else begin
                ram_wen_o <= '1;
            end
        end
    end

    // Read-return pipeline: tag at the command beat, rvalid when RAM data is out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            tag_q.vld <= accept & ~(|acc_be);
            tag_q.who <= gnt1;
            rvalid0   <= tag_q.vld & ~tag_q.who;
            rvalid1   <= tag_q.vld & tag_q.who;
        end
    end

endmodule

// File: tb/tb_ram_be_arbiter.sv
// Bench for ram_be_arbiter: RAM model, rule-level reference model, per-cycle compare.
module tb_ram_be_arbiter;
    localparam int unsigned WW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned BW = WW / 8;
    localparam int unsigned ML = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ram_be_arbiter_if #(.Word_Width(WW), .Addr_Width(AW)) bus ();

    logic          ram_cen;
    logic          ram_oen;
    logic [BW-1:0] ram_wen;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata;
    logic [WW-1:0] ram_q = '0;

    ram_be_arbiter #(.Word_Width(WW), .Addr_Width(AW), .Max_Lock(ML)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .ram_cen_o  (ram_cen),
        .ram_oen_o  (ram_oen),
        .ram_wen_o  (ram_wen),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_wdata),
        .ram_data_i (ram_q)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] init_word(input int i);
        if (i == 'h10) return 32'hDEADBEEF;
        if (i == 'h20) return 32'hAAAAAAAA;
        return (32'(i) * 32'h01010101) ^ 32'h5A3C_96E1;
    endfunction

    // Synchronous byte-enable RAM with registered read data
    logic [WW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (!ram_cen) begin
                for (int b = 0; b < int'(BW); b++)
                    if (!ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                if ((&ram_wen) && !ram_oen) ram_q <= mem[ram_addr];
            end
        end
    end

    // Reference model state (rule level)
    logic [WW-1:0] ref_mem [256];
    int            owner    = -1;  // -1 none, else locked requester
    int            last_gnt = 1;   // requester granted most recently
    int            streak   = 0;   // owner grants while the other waits
    bit            exp_oen  = 1'b1;
    bit            exp_cen  = 1'b1;
    logic [BW-1:0] exp_wen  = '1;
    logic [AW-1:0] exp_addr = '0;
    logic [WW-1:0] exp_data = '0;
    bit            s1_v = 0, s1_who = 0, s2_v = 0, s2_who = 0;
    logic [WW-1:0] s1_data = '0, s2_data = '0;

    function automatic void model_gnt(output bit g0, output bit g1);
        bit r0 = (bus.req0_i === 1'b1);
        bit r1 = (bus.req1_i === 1'b1);
        g0 = 0;
        g1 = 0;
        if (owner == 0)       g0 = r0;
        else if (owner == 1)  g1 = r1;
        else if (r0 && r1) begin
            if (last_gnt == 1) g0 = 1; else g1 = 1;
        end else begin
            g0 = r0;
            g1 = r1;
        end
    endfunction

    task automatic model_step();
        bit g0, g1, r0, r1, lk, oth;
        int acc;
        logic [BW-1:0] be;
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        if (!rstn) begin
            owner = -1; last_gnt = 1; streak = 0;
            exp_oen = 1; exp_cen = 1; exp_wen = '1; exp_addr = '0; exp_data = '0;
            s1_v = 0; s2_v = 0;
            return;
        end
        model_gnt(g0, g1);
        r0 = bus.req0_i;
        r1 = bus.req1_i;
        exp_oen = 0;
        s2_v = s1_v; s2_who = s1_who; s2_data = s1_data;
        s1_v = 0;
        acc = g0 ? 0 : (g1 ? 1 : -1);
        lk = 0;
        if (acc >= 0) begin
            be = (acc == 1) ? bus.be1_i   : bus.be0_i;
            a  = (acc == 1) ? bus.addr1_i : bus.addr0_i;
            d  = (acc == 1) ? bus.data1_i : bus.data0_i;
            lk = (acc == 1) ? bus.lock1_i : bus.lock0_i;
            exp_cen = 0; exp_wen = ~be; exp_addr = a; exp_data = d;
            if (be == '0) begin
                s1_v = 1; s1_who = (acc == 1); s1_data = ref_mem[a];
            end else begin
                for (int b = 0; b < int'(BW); b++)
                    if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end
            last_gnt = acc;
        end else begin
            exp_cen = 1; exp_wen = '1;
        end
        if (owner < 0) begin
            if (acc >= 0 && lk) begin
                oth = (acc == 0) ? r1 : r0;
                streak = oth ? 1 : 0;
                if (streak >= int'(ML)) streak = 0; else owner = acc;
            end
        end else begin
            oth = (owner == 0) ? r1 : r0;
            if (acc == owner) begin
                if (!lk) begin
                    owner = -1; streak = 0;
                end else begin
                    streak = oth ? streak + 1 : 0;
                    if (streak >= int'(ML)) begin owner = -1; streak = 0; end
                end
            end else if (oth) begin
                owner = -1; streak = 0;
            end else begin
                streak = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit g0, g1;
        model_gnt(g0, g1);
        chk("gnt0", bus.gnt0_o, g0);
        chk("gnt1", bus.gnt1_o, g1);
        if (!rstn) begin
            chk("rst_cen", ram_cen, 1);
            chk("rst_oen", ram_oen, 1);
            chk("rst_wen", ram_wen, {BW{1'b1}});
            chk("rst_addr", ram_addr, 0);
            chk("rst_data", ram_wdata, 0);
            chk("rst_rvalid0", bus.rvalid0_o, 0);
            chk("rst_rvalid1", bus.rvalid1_o, 0);
        end else begin
            chk("cen", ram_cen, exp_cen);
            chk("oen", ram_oen, exp_oen);
            chk("wen", ram_wen, exp_wen);
            if (!exp_cen) begin
                chk("addr", ram_addr, exp_addr);
                chk("wdata", ram_wdata, exp_data);
            end
            chk("rvalid0", bus.rvalid0_o, s2_v && !s2_who);
            chk("rvalid1", bus.rvalid1_o, s2_v && s2_who);
            if (s2_v) chk("rdata", bus.rdata_o, s2_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit r, input logic [BW-1:0] be, input logic [AW-1:0] a,
                          input logic [WW-1:0] d, input bit lk);
        bus.req0_i = r; bus.be0_i = be; bus.addr0_i = a; bus.data0_i = d; bus.lock0_i = lk;
    endtask

    task automatic drive1(input bit r, input logic [BW-1:0] be, input logic [AW-1:0] a,
                          input logic [WW-1:0] d, input bit lk);
        bus.req1_i = r; bus.be1_i = be; bus.addr1_i = a; bus.data1_i = d; bus.lock1_i = lk;
    endtask

    task automatic rand_payload(output logic [BW-1:0] be, output logic [AW-1:0] a,
                                output logic [WW-1:0] d, output bit lk);
        be = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
        a  = AW'($urandom_range(0, 15)) + 8'h40;
        d  = $urandom;
        lk = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        bit g0p, g1p, got;
        logic [BW-1:0] be;
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        bit lk;

        drive0(0, '0, '0, '0, 0);
        drive1(0, '0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Single read of a preloaded word
        drive0(1, '0, 8'h10, '0, 0);
        @(negedge clk); chk("d1_gnt0", bus.gnt0_o, 1);
        tick(); drive0(0, '0, '0, '0, 0);
        @(negedge clk); chk("d1_cen", ram_cen, 0);
        tick();
        @(negedge clk);
        chk("d1_rvalid0", bus.rvalid0_o, 1);
        chk("d1_rdata", bus.rdata_o, 32'hDEADBEEF);
        chk("d1_rvalid1", bus.rvalid1_o, 0);

        // Partial write then read-after-write
        tick(); drive0(1, 4'b0011, 8'h20, 32'h12345678, 0);
        @(negedge clk); chk("d2_gnt_wr", bus.gnt0_o, 1);
        tick(); drive0(1, '0, 8'h20, '0, 0);
        @(negedge clk); chk("d2_wen", ram_wen, 4'b1100);
        tick(); drive0(0, '0, '0, '0, 0);
        tick();
        @(negedge clk);
        chk("d2_rvalid0", bus.rvalid0_o, 1);
        chk("d2_rdata", bus.rdata_o, 32'hAAAA5678);

        // Both requesting, no lock: alternation starting with requester 1
        for (int i = 0; i < 7; i++) begin
            tick();
            drive0(1, '0, AW'(i), '0, 0);
            drive1(1, '0, AW'(i + 8), '0, 0);
            @(negedge clk); chk("d3_alt_gnt1", bus.gnt1_o, (i % 2) == 0);
        end

        // Requester 0 locks while requester 1 waits: bounded by ML grants
        for (int i = 0; i < 7; i++) begin
            tick();
            drive0(1, '0, AW'(i + 16), '0, i < 5);
            drive1(1, '0, 8'h30, '0, 0);
            @(negedge clk); chk("d4_lock_gnt0", bus.gnt0_o, (i < 4) || (i == 5));
        end
        tick();
        drive0(0, '0, '0, '0, 0);
        drive1(0, '0, '0, '0, 0);

        // Randomised traffic; a pending request keeps its payload until granted
        g0p = 0; g1p = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!(bus.req0_i && !g0p)) begin
                rand_payload(be, a, d, lk);
                drive0($urandom_range(0, 9) < 7, be, a, d, lk);
            end
            if (!(bus.req1_i && !g1p)) begin
                rand_payload(be, a, d, lk);
                drive1($urandom_range(0, 9) < 7, be, a, d, lk);
            end
            @(negedge clk);
            g0p = bus.gnt0_o;
            g1p = bus.gnt1_o;
        end

        // Reset while a read is in flight
        tick();
        drive0(1, '0, 8'h10, '0, 0);
        drive1(0, '0, '0, '0, 0);
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (bus.gnt0_o) got = 1; else tick();
        end
        chk("d5_pre_gnt0", got, 1);
        tick();
        rstn = 1'b0;
        drive0(0, '0, '0, '0, 0);
        @(negedge clk);
        chk("d5_cen", ram_cen, 1);
        chk("d5_wen", ram_wen, 4'hF);
        chk("d5_oen", ram_oen, 1);
        chk("d5_rvalid0", bus.rvalid0_o, 0);
        tick(); tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("d5_post_rvalid0", bus.rvalid0_o, 0);
            chk("d5_post_rvalid1", bus.rvalid1_o, 0);
            tick();
        end
        drive0(1, '0, 8'h11, '0, 0);
        drive1(1, '0, 8'h12, '0, 0);
        @(negedge clk);
        chk("d5_prio_gnt0", bus.gnt0_o, 1);
        chk("d5_prio_gnt1", bus.gnt1_o, 0);
        tick();
        drive0(0, '0, '0, '0, 0);
        drive1(0, '0, '0, '0, 0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_be_arbiter.md
Name: ram_be_arbiter

Overview:
- Two-requester arbiter that shares one port of the byte-enable dual-port RAM model.
- It converts per-requester active-high requests and byte-write strobes into the RAM's low-active cen/oen/wen controls.
- It applies round-robin arbitration with optional bounded lock (burst hold).
- It returns read data to the requester that issued the read, tagged by a valid strobe.
- Typical users are two encoder engines, e.g. a fetch engine and a writeback engine, sharing one reference-buffer port.

Parameters:
- Word_Width, 32, RAM word width in bits; must be a multiple of 8; Byte_Width = Word_Width/8 (localparam).
- Addr_Width, 8, RAM address width.
- Max_Lock, 4, maximum consecutive grants a locked requester may hold while the other requester is waiting (min 1).

Ports:
- clk  in  1  single clock (RAM clock shares it).
- rstn  in  1  asynchronous active-low reset.
- req0_i / req1_i  in  1  access request; held until granted.
- be0_i / be1_i  in  Byte_Width  active-high byte write strobes; all-zero means read.
- addr0_i / addr1_i  in  Addr_Width  access address.
- data0_i / data1_i  in  Word_Width  write data.
- lock0_i / lock1_i  in  1  request to keep ownership for the following beat.
- gnt0_o / gnt1_o  out  1  combinational grant; request is accepted in the cycle where req&gnt=1.
- rvalid0_o / rvalid1_o  out  1  read data valid for that requester.
- rdata_o  out  Word_Width  read data, shared; meaningful only when an rvalid is high.
- ram_cen_o  out  1  RAM chip enable, low active, registered.
- ram_oen_o  out  1  RAM output enable, low active, registered.
- ram_wen_o  out  Byte_Width  RAM byte write enable, low active, registered (= ~be).
- ram_addr_o  out  Addr_Width  registered address.
- ram_data_o  out  Word_Width  registered write data.
- ram_data_i  in  Word_Width  RAM data output.

Behaviour:
- Reset values:
  - ram_cen_o=1, ram_oen_o=1, ram_wen_o=all 1, ram_addr_o=0, ram_data_o=0.
  - rvalid*=0, FSM=ARB, rr pointer=0 (req0 has priority), lock counter=0.
- Reset is asynchronous and may assert mid-access; in-flight reads are dropped and no rvalid follows reset release.
- Outputs after reset:
  - ram_oen_o goes 0 on the first clock after reset release and stays 0.
  - gnt*_o is 0 whenever req*_i is 0.
- At most one grant per cycle; one access per cycle maximum, so full throughput is possible.
- Pipeline, accept in cycle t:
  - t+1: RAM command present, ram_cen_o=0, wen/addr/data registered.
  - t+2: the RAM has registered the read, and rvalidN_o=1 with rdata_o=ram_data_i for a read (be=0).
  - Writes produce no rvalid.
  - With no accept in t, ram_cen_o=1 and ram_wen_o=all 1 in t+1.
- Read-after-write to the same address in consecutive accepts returns the new data. The RAM write completes at the end of t+1; the read executes at the end of t+2.
- FSM states and transitions:
  - ARB, round-robin: the requester granted last has lower priority. With only one requester active, it is granted every cycle.
  - LOCK0 / LOCK1: entered from ARB when requester N is accepted with lockN_i=1. While in LOCKN, only N may be granted.
  - In LOCKN, the lock counter increments on each accept by N while the other requester is requesting. It is cleared when the other requester is idle.
  - LOCKN returns to ARB when:
    - N is accepted with lockN_i=0, or
    - reqN_i=0 in a cycle while the other requester is requesting, or
    - the counter reaches Max_Lock.
  - On a Max_Lock exit, the other requester is granted next and the pointer favours it.
  - In LOCKN with both requests low, the FSM stays in LOCKN (idle hold).
- Simultaneous req0/req1 in ARB with pointer=0: req0 is granted, then pointer=1.

Decomposition:
- Shared package/header (enc_defines): FSM state encodings (ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2) and the default widths.
- One sub-module is natural: ram_rr_arb2, the combinational 2-way round-robin grant plus pointer register.
- Lock FSM, command register and read-return pipeline stay in the top.

Test Plan:
- Reset then req0 read at addr 0x10, RAM preloaded 0xDEADBEEF: gnt0 in cycle t, ram_cen_o=0 in t+1, rvalid0=1 with rdata_o=0xDEADBEEF in t+2, rvalid1 stays 0.
- req0 write be=4'b0011 data 0x12345678 to addr 0x20 (old 0xAAAAAAAA), then read 0x20 next cycle: ram_wen_o=4'b1100; read returns 0xAAAA5678.
- Both requesting continuously, no lock: grants alternate 0,1,0,1; rvalid0/rvalid1 alternate two cycles later.
- req0 with lock0=1 continuously, req1 waiting, Max_Lock=4: exactly 4 consecutive gnt0, then gnt1, then alternation resumes.
- Assert rstn low in the cycle after a read is accepted: all RAM controls return to inactive immediately; no rvalid after release; FSM in ARB with req0 priority.
